// File: rtl/memory_pkg.sv
// Shared types and lane-formatting helpers for the OTTER memory stage.
package memory_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [4:0]  rd;
        logic [1:0]  rf_wr_sel;
        logic [31:0] pc_4;
        logic [31:0] alu_result;
        logic [31:0] dout2;
    } wb_t;

    // Operation captured while the bus access is outstanding
    typedef struct packed {
        logic [1:0]  size;
        logic        is_unsigned;
        logic        is_store;
        logic        regwrite;
        logic [4:0]  rd;
        logic [1:0]  rf_wr_sel;
        logic [31:0] pc_4;
        logic [31:0] alu_result;
    } op_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
        logic [31:0] wd;
        case (size)
            SZ_BYTE: wd = {4{rs2[7:0]}};
            SZ_HALF: wd = {2{rs2[15:0]}};
            default: wd = rs2;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] load_format(input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        is_unsigned,
                                                input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {off, 3'b000};
        case (size)
            SZ_BYTE: res = is_unsigned ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: res = is_unsigned ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering: store enables/data, load extraction, alignment check.
module load_store_align
    import memory_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_store,
    input  logic        is_unsigned,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    always_comb begin
        be         = is_store ? store_be(size, addr_lo) : 4'b1111;
        wdata      = is_store ? store_wdata(size, rs2) : 32'h0;
        load_data  = load_format(size, addr_lo, is_unsigned, rdata);
        misaligned = is_misaligned(size, addr_lo);
    end

endmodule

// File: rtl/memory_state_access.sv
// OTTER memory stage: issues data-memory loads/stores over req/ack and fills MEM/WB.
module memory_state_access
    import memory_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int ADDR_W      = 32
) (
    input  logic              MEMORY_CLOCK,
    input  logic              MEMORY_RESET_N,
    input  logic              EXEC_VALID,
    input  logic [31:0]       EXEC_PC_4,
    input  logic [31:0]       EXEC_ALU_RESULT,
    input  logic [31:0]       EXEC_RS2,
    input  logic [1:0]        EXEC_RF_WR_SEL,
    input  logic              EXEC_REGWRITE,
    input  logic              EXEC_MEMWRITE,
    input  logic              EXEC_MEMREAD2,
    input  logic [1:0]        EXEC_MEM_SIZE,
    input  logic              EXEC_MEM_UNSIGNED,
    input  logic [4:0]        EX_MS_RD,
    output logic              MEM_STALL,
    output logic              DMEM_REQ,
    output logic              DMEM_WE,
    output logic [ADDR_W-1:0] DMEM_ADDR,
    output logic [31:0]       DMEM_WDATA,
    output logic [3:0]        DMEM_BE,
    input  logic              DMEM_ACK,
    input  logic [31:0]       DMEM_RDATA,
    output logic              MEM_FAULT,
    output logic              MS_WB_VALID,
    output logic              MS_WB_REGWRITE,
    output logic [31:0]       MS_WB_PC_4,
    output logic [31:0]       MS_WB_ALU_RESULT,
    output logic [31:0]       MS_WB_DOUT2,
    output logic [1:0]        MS_WB_RF_WR_SEL,
    output logic [4:0]        MS_WB_RD
);

    localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    op_t                op_q, op_d;
    wb_t                wb_q, wb_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic               fault_q, fault_d;

    logic               mem_op;
    logic               waiting;
    logic [31:0]        word_addr;
    logic [1:0]         al_off, al_size;
    logic               al_store, al_unsigned;
    logic [3:0]         al_be;
    logic [31:0]        al_wdata, al_load;
    logic               al_misaligned;

    assign mem_op    = EXEC_VALID & (EXEC_MEMREAD2 | EXEC_MEMWRITE);
    assign waiting   = (state_q == WAIT_ACK);
    assign word_addr = {EXEC_ALU_RESULT[31:2], 2'b00};

    // One aligner serves both phases: EX/MEM fields while idle, the latched op while waiting
    assign al_off      = waiting ? op_q.alu_result[1:0] : EXEC_ALU_RESULT[1:0];
    assign al_size     = waiting ? op_q.size            : EXEC_MEM_SIZE;
    assign al_store    = waiting ? op_q.is_store        : EXEC_MEMWRITE;
    assign al_unsigned = waiting ? op_q.is_unsigned     : EXEC_MEM_UNSIGNED;

    load_store_align u_align (
        .addr_lo     (al_off),
        .size        (al_size),
        .is_store    (al_store),
        .is_unsigned (al_unsigned),
        .rs2         (EXEC_RS2),
        .rdata       (DMEM_RDATA),
        .be          (al_be),
        .wdata       (al_wdata),
        .load_data   (al_load),
        .misaligned  (al_misaligned)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        wb_d      = wb_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        fault_d   = 1'b0;
        MEM_STALL = 1'b0;

        case (state_q)
            IDLE: begin
                if (!mem_op) begin
                    wb_d.valid      = EXEC_VALID;
                    wb_d.regwrite   = EXEC_VALID & EXEC_REGWRITE;
                    wb_d.rd         = EX_MS_RD;
                    wb_d.rf_wr_sel  = EXEC_RF_WR_SEL;
                    wb_d.pc_4       = EXEC_PC_4;
                    wb_d.alu_result = EXEC_ALU_RESULT;
                    wb_d.dout2      = 32'h0;
                end else begin
                    wb_d = '0;
                    if (al_misaligned) begin
                        fault_d = 1'b1;
                    end else begin
                        MEM_STALL        = 1'b1;
                        op_d.size        = EXEC_MEM_SIZE;
                        op_d.is_unsigned = EXEC_MEM_UNSIGNED;
                        op_d.is_store    = EXEC_MEMWRITE;
                        op_d.regwrite    = EXEC_REGWRITE;
                        op_d.rd          = EX_MS_RD;
                        op_d.rf_wr_sel   = EXEC_RF_WR_SEL;
                        op_d.pc_4        = EXEC_PC_4;
                        op_d.alu_result  = EXEC_ALU_RESULT;
                        req_d            = 1'b1;
                        we_d             = EXEC_MEMWRITE;
                        addr_d           = word_addr[ADDR_W-1:0];
                        be_d             = al_be;
                        wdata_d          = al_wdata;
                        cnt_d            = '0;
                        state_d          = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                MEM_STALL = ~DMEM_ACK;
                // ACK is checked first so a completion on the last allowed cycle still retires
                if (DMEM_ACK) begin
                    req_d           = 1'b0;
                    we_d            = 1'b0;
                    wb_d.valid      = 1'b1;
                    wb_d.regwrite   = op_q.regwrite;
                    wb_d.rd         = op_q.rd;
                    wb_d.rf_wr_sel  = op_q.rf_wr_sel;
                    wb_d.pc_4       = op_q.pc_4;
                    wb_d.alu_result = op_q.alu_result;
                    wb_d.dout2      = op_q.is_store ? 32'h0 : al_load;
                    state_d         = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    fault_d = 1'b1;
                    wb_d    = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MEMORY_CLOCK or negedge MEMORY_RESET_N) begin
        if (!MEMORY_RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            wb_q    <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            wb_q    <= wb_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            fault_q <= fault_d;
        end
    end

    assign DMEM_REQ         = req_q;
    assign DMEM_WE          = we_q;
    assign DMEM_ADDR        = addr_q;
    assign DMEM_WDATA       = wdata_q;
    assign DMEM_BE          = be_q;
    assign MEM_FAULT        = fault_q;
    assign MS_WB_VALID      = wb_q.valid;
    assign MS_WB_REGWRITE   = wb_q.regwrite;
    assign MS_WB_RD         = wb_q.rd;
    assign MS_WB_RF_WR_SEL  = wb_q.rf_wr_sel;
    assign MS_WB_PC_4       = wb_q.pc_4;
    assign MS_WB_ALU_RESULT = wb_q.alu_result;
    assign MS_WB_DOUT2      = wb_q.dout2;

endmodule
